// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder_if
//  Function : Request/response bundle between an initiator and the data
//             memory responder. The master drives a request; the slave
//             returns read data, a one-cycle ack, an error flag and busy.
//  Revision : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ack, err, busy
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ack, err, busy
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Function : Word-organised data memory with a fixed-latency request/ack
//             protocol. A request is captured in IDLE, held for WAIT_STATES
//             cycles, then completed with a one-cycle ack. Writes honour
//             byte enables and commit at the end of the ack cycle; read data
//             is held until the next read completes.
//  Options  : DMEM_ALIGN_CHECK_EN - flag requests with addr[1:0] != 0 as
//             errors (no write, read data unchanged). Undefined by default:
//             the low address bits are ignored and err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  wire logic           clk_i,
    input  wire logic           rst_ni,
    data_mem_responder_if.slave bus
);

    localparam int         c_AW        = $clog2(DEPTH_WORDS);
    localparam bit         c_HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [3:0] c_WAIT_LOAD = c_HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [c_AW-1:0]     idx_q;
    logic [31:0]         wdata_q;
    logic [3:0]          be_q;
    logic [31:0]         rdata_q;
    logic [31:0]         mem_q [DEPTH_WORDS];

    logic                w_accept;
    logic                w_ack;
    logic                w_mis;
    logic                w_rd_en;
    logic                w_wr_en;

    // Address bits outside the word index carry no meaning here.
    logic                w_unused_addr;
    assign w_unused_addr = ^{bus.addr[31:c_AW+2], bus.addr[1:0]};

    assign w_accept = (state_q == S_IDLE) && bus.req;
    assign w_ack    = (state_q == S_ACK);

`ifdef DMEM_ALIGN_CHECK_EN
    logic mis_q;

    // Remember whether the captured request was misaligned.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mis_q <= 1'b0;
        end else if (w_accept) begin
            mis_q <= (bus.addr[1:0] != 2'b00);
        end
    end

    assign w_mis = mis_q;
`else
    assign w_mis = 1'b0;
`endif

    // A misaligned request completes but must not touch storage or rdata.
    assign w_rd_en = w_ack && !we_q && !w_mis;
    assign w_wr_en = w_ack &&  we_q && !w_mis;

    assign bus.ack   = w_ack;
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.err   = w_ack && w_mis;
    // Reading storage directly in ACK makes a write from the previous
    // transaction visible without a bypass path.
    assign bus.rdata = w_rd_en ? mem_q[idx_q] : rdata_q;

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    cnt_d   = c_WAIT_LOAD;
                    state_d = c_HAS_WAIT ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter and captured-request registers; rdata holds last read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                we_q    <= bus.we;
                idx_q   <= bus.addr[c_AW+1:2];
                wdata_q <= bus.wdata;
                be_q    <= bus.be;
            end
            if (w_rd_en) begin
                rdata_q <= mem_q[idx_q];
            end
        end
    end

    // Byte-masked write at the edge that ends the ACK cycle; storage is
    // deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Function : Scoreboard bench. Two responders share clock and reset: A uses
//             two wait states, B uses none. Every accepted request pushes an
//             expectation (ack cycle, err, request fields); each ack pops it
//             and the read data is predicted from a byte-level memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int WS_A = 2;
    localparam int WS_B = 0;

    typedef struct {
        logic        we;
        logic [7:0]  idx;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        mis;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_pass;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] mdl_a [256];
    logic [31:0] mdl_b [256];
    logic [31:0] last_a;
    logic [31:0] last_b;
    int          ack_cyc_b[$];
    int          busy_cnt_b;

    data_mem_responder_if ifa ();
    data_mem_responder_if ifb ();

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WS_A)) u_dut_a (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (ifa)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WS_B)) u_dut_b (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic mis_of(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
        return (a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    // Responder A: retire acks against the scoreboard, then log new accepts.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] er;
        if (rst_n) begin
            if (ifa.ack) begin
                if (q_a.size() == 0) begin
                    chk("unexpected_ack_a", 32'd1, 32'd0);
                end else begin
                    e  = q_a.pop_front();
                    er = (e.we || e.mis) ? last_a : mdl_a[e.idx];
                    chk("ack_cycle_a", 32'(cyc), 32'(e.cyc));
                    chk("err_a", {31'd0, ifa.err}, {31'd0, e.mis});
                    chk("rdata_a", ifa.rdata, er);
                    last_a = er;
                    if (e.we && !e.mis)
                        for (int b = 0; b < 4; b++)
                            if (e.be[b]) mdl_a[e.idx][8*b +: 8] = e.wdata[8*b +: 8];
                end
            end
            if (ifa.req && !ifa.busy) begin
                e.we = ifa.we; e.idx = ifa.addr[9:2]; e.wdata = ifa.wdata;
                e.be = ifa.be; e.mis = mis_of(ifa.addr); e.cyc = cyc + WS_A + 1;
                q_a.push_back(e);
            end
        end
    end

    // Responder B: same scoreboard flow plus ack-time and busy logging.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] er;
        if (rst_n) begin
            if (ifb.busy) busy_cnt_b++;
            if (ifb.ack) begin
                ack_cyc_b.push_back(cyc);
                if (q_b.size() == 0) begin
                    chk("unexpected_ack_b", 32'd1, 32'd0);
                end else begin
                    e  = q_b.pop_front();
                    er = (e.we || e.mis) ? last_b : mdl_b[e.idx];
                    chk("ack_cycle_b", 32'(cyc), 32'(e.cyc));
                    chk("err_b", {31'd0, ifb.err}, {31'd0, e.mis});
                    chk("rdata_b", ifb.rdata, er);
                    last_b = er;
                    if (e.we && !e.mis)
                        for (int b = 0; b < 4; b++)
                            if (e.be[b]) mdl_b[e.idx][8*b +: 8] = e.wdata[8*b +: 8];
                end
            end
            if (ifb.req && !ifb.busy) begin
                e.we = ifb.we; e.idx = ifb.addr[9:2]; e.wdata = ifb.wdata;
                e.be = ifb.be; e.mis = mis_of(ifb.addr); e.cyc = cyc + WS_B + 1;
                q_b.push_back(e);
            end
        end
    end

    // Wait, bounded, until a responder is idle with nothing outstanding.
    task automatic drain(input int d);
        int i;
        for (i = 0; i < 40; i++) begin
            if (d == 0 && q_a.size() == 0 && !ifa.busy) break;
            if (d == 1 && q_b.size() == 0 && !ifb.busy) break;
            @(posedge clk); #1;
        end
        chk(d == 0 ? "drain_timeout_a" : "drain_timeout_b", 32'(i < 40), 32'd1);
    endtask

    // Present one request for a single accept edge, then scramble the
    // inputs so any late re-sampling would corrupt the transaction.
    task automatic txn(input int d, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] b);
        @(posedge clk); #1;
        if (d == 0) begin
            ifa.req = 1'b1; ifa.we = w; ifa.addr = a; ifa.wdata = wd; ifa.be = b;
        end else begin
            ifb.req = 1'b1; ifb.we = w; ifb.addr = a; ifb.wdata = wd; ifb.be = b;
        end
        @(posedge clk); #1;
        if (d == 0) begin
            ifa.req = 1'b0; ifa.we = 1'($urandom); ifa.addr = $urandom;
            ifa.wdata = $urandom; ifa.be = 4'($urandom);
        end else begin
            ifb.req = 1'b0; ifb.we = 1'($urandom); ifb.addr = $urandom;
            ifb.wdata = $urandom; ifb.be = 4'($urandom);
        end
        drain(d);
    endtask

    initial begin
        cyc = 0; n_chk = 0; n_pass = 0; busy_cnt_b = 0;
        last_a = 32'd0; last_b = 32'd0;
        rst_n = 1'b0;
        ifa.req = 1'b0; ifa.we = 1'b0; ifa.addr = 32'd0; ifa.wdata = 32'd0; ifa.be = 4'd0;
        ifb.req = 1'b0; ifb.we = 1'b0; ifb.addr = 32'd0; ifb.wdata = 32'd0; ifb.be = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", {31'd0, ifa.ack}, 32'd0);
        chk("rst_busy", {31'd0, ifa.busy}, 32'd0);
        chk("rst_err", {31'd0, ifa.err}, 32'd0);
        chk("rst_rdata", ifa.rdata, 32'd0);
        rst_n = 1'b1;

        // Full write then read-back, partial write, empty byte mask.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
        txn(0, 1'b0, 32'h10, 32'h0, 4'b0000);
        chk("rd_deadbeef", last_a, 32'hDEADBEEF);
        txn(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001);
        txn(0, 1'b0, 32'h10, 32'h0, 4'b0000);
        chk("rd_deadbeaa", last_a, 32'hDEADBEAA);
        txn(0, 1'b1, 32'h10, 32'h00000000, 4'b0000);
        txn(0, 1'b0, 32'h10, 32'h0, 4'b0000);
        chk("rd_be0000", last_a, 32'hDEADBEAA);
        txn(0, 1'b1, 32'h4C, 32'hC001D00D, 4'b1010);
        txn(0, 1'b1, 32'h4C, 32'h55667788, 4'b0101);
        txn(0, 1'b0, 32'h4C, 32'h0, 4'b0000);
        chk("rd_merge", last_a, 32'hC066D088);

        // Address wrap modulo 1 KiB.
        txn(0, 1'b1, 32'h400, 32'h12345678, 4'b1111);
        txn(0, 1'b0, 32'h000, 32'h0, 4'b0000);
        chk("rd_wrap", last_a, 32'h12345678);

        // Reset in the middle of a write abandons it.
        txn(0, 1'b1, 32'h20, 32'h00000000, 4'b1111);
        @(posedge clk); #1;
        ifa.req = 1'b1; ifa.we = 1'b1; ifa.addr = 32'h20; ifa.wdata = 32'hFFFFFFFF; ifa.be = 4'hF;
        @(posedge clk); #1;
        ifa.req = 1'b0;
        @(negedge clk);
        chk("wait_busy", {31'd0, ifa.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, ifa.busy}, 32'd0);
        chk("midrst_ack", {31'd0, ifa.ack}, 32'd0);
        chk("midrst_rdata", ifa.rdata, 32'd0);
        q_a.delete(); q_b.delete();
        last_a = 32'd0; last_b = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        txn(0, 1'b0, 32'h20, 32'h0, 4'b0000);
        chk("rd_after_abort", last_a, 32'h00000000);

        // Misaligned write and read.
        txn(0, 1'b0, 32'h10, 32'h0, 4'b0000);
        txn(0, 1'b1, 32'h22, 32'h55AA55AA, 4'b1111);
        txn(0, 1'b0, 32'h20, 32'h0, 4'b0000);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("misalign_wr", last_a, 32'h00000000);
`else
        chk("misalign_wr", last_a, 32'h55AA55AA);
`endif
        txn(0, 1'b0, 32'h10, 32'h0, 4'b0000);
        txn(0, 1'b0, 32'h23, 32'h0, 4'b0000);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("misalign_rd", last_a, 32'hDEADBEAA);
`else
        chk("misalign_rd", last_a, 32'h55AA55AA);
`endif

        // Zero wait states: seed two words, then two reads with req held.
        txn(1, 1'b1, 32'h0, 32'h11111111, 4'b1111);
        txn(1, 1'b1, 32'h4, 32'h22222222, 4'b1111);
        ack_cyc_b.delete();
        busy_cnt_b = 0;
        @(posedge clk); #1;
        ifb.req = 1'b1; ifb.we = 1'b0; ifb.addr = 32'h0; ifb.be = 4'h0;
        @(posedge clk); #1;
        ifb.addr = 32'h4;
        @(posedge clk);
        @(posedge clk); #1;
        ifb.req = 1'b0;
        drain(1);
        repeat (3) @(posedge clk);
        chk("b2b_last_rd", last_b, 32'h22222222);
        chk("b2b_busy_cycles", 32'(busy_cnt_b), 32'd2);
        chk("b2b_ack_count", 32'(ack_cyc_b.size()), 32'd2);
        if (ack_cyc_b.size() == 2)
            chk("b2b_ack_spacing", 32'(ack_cyc_b[1] - ack_cyc_b[0]), 32'd2);

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words of storage (power of two, 16..4096).
REQ-002 Parameter WAIT_STATES, default 2, idle cycles between request accept and ack (0..15).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  1  initiator request strobe, sampled only in IDLE.
REQ-006 we  input  1  1 = write, 0 = read.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  write data.
REQ-009 be  input  4  byte enables for writes, be[0] = bits 7:0.
REQ-010 rdata  output  32  read data, valid when ack=1.
REQ-011 ack  output  1  one-cycle completion pulse.
REQ-012 err  output  1  error flag, valid when ack=1.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states IDLE, WAIT, ACK; encoding free.
REQ-015 In IDLE with req=1, the block captures we, addr, wdata and be into internal registers and goes to WAIT if WAIT_STATES>0, else to ACK.
REQ-016 On accept, wait counter loads WAIT_STATES-1; WAIT decrements each cycle and goes to ACK on the cycle after the counter reads 0.
REQ-017 Accept-to-ack latency is exactly WAIT_STATES+1 cycles (ack high in cycle N+WAIT_STATES+1 when req is sampled in cycle N).
REQ-018 ACK lasts exactly one cycle, then returns to IDLE; the earliest next accept is the cycle after ack.
REQ-019 req, we, addr, wdata, be are ignored outside IDLE; changes mid-transaction do not affect the captured request.
REQ-020 Word index = captured addr bits [log2(DEPTH_WORDS)+1:2]; higher address bits are ignored (address wraps modulo DEPTH_WORDS*4).
REQ-021 Write commits on the clock edge ending the ACK cycle, updating only the bytes whose be bit is 1; be=0000 completes with ack and no change.
REQ-022 For reads, rdata equals the stored word during the ACK cycle and holds that value until the next read ack; writes do not change rdata.
REQ-023 A read of a word written by the immediately preceding transaction returns the new data.
REQ-024 err=0 whenever ack=0.
REQ-025 busy = (state != IDLE); ack and busy are both high during ACK.

Reset
REQ-026 rst=0 forces, asynchronously, state=IDLE, ack=0, err=0, busy=0, rdata=0, and clears the wait counter and captured registers.
REQ-027 Reset mid-transaction abandons it: no write commits and no ack is produced after reset release.
REQ-028 Storage contents are not cleared by reset and are undefined at power-up.
REQ-029 The first accept happens no earlier than the first rising edge with rst=1.

Configuration
REQ-030 Macro DMEM_ALIGN_CHECK_EN.
REQ-031 With DMEM_ALIGN_CHECK_EN defined: a request with addr[1:0]!=00 completes with normal latency, ack=1 and err=1, performs no write, and leaves rdata unchanged.
REQ-032 Without DMEM_ALIGN_CHECK_EN: addr[1:0] is ignored, err is tied to 0, and misaligned requests act on the containing word.

Verification
REQ-033 Reset, then write 0xDEADBEEF to addr 0x10 with be=1111 and WAIT_STATES=2 -> ack in the 3rd cycle after accept, err=0; a read of 0x10 then returns 0xDEADBEEF.
REQ-034 Write 0x000000AA to 0x10 with be=0001 over 0xDEADBEEF -> a read of 0x10 returns 0xDEADBEAA.
REQ-035 WAIT_STATES=0: issue back-to-back reads of 0x0 and 0x4 with req held high -> ack one cycle after each accept, the accepts are two cycles apart, and busy is high for exactly one cycle per transaction.
REQ-036 Address wrap: DEPTH_WORDS=256, write 0x12345678 to 0x400 -> a read of 0x000 returns 0x12345678.
REQ-037 Pull rst low during WAIT of a write of 0xFFFFFFFF to 0x20 (previously 0x0) -> no ack, busy=0 immediately, and a later read of 0x20 returns 0x0.
REQ-038 With DMEM_ALIGN_CHECK_EN defined, write to 0x22 -> ack=1 and err=1, word 0x20 is unchanged; without the macro the same write updates word 0x20 and err=0.
